// File: rtl/snoop_responder.sv
// Responder side of the shared-bus snoop protocol: tag lookup, MESI update,
// snoop result, L2-to-L1 message and HITM writeback for the last-level cache.
module snoop_responder #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned OFFSET_BITS   = 6,
  parameter int unsigned INDEX_BITS    = 14,
  parameter int unsigned WAY_BITS      = 4,
  parameter int unsigned TAG_BITS      = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     snoop_valid,
  output logic                     snoop_ready,
  input  logic [2:0]               snoop_op,
  input  logic [ADDRESS_WIDTH-1:0] snoop_addr,
  output logic                     lk_req,
  output logic [INDEX_BITS-1:0]    lk_index,
  output logic [TAG_BITS-1:0]      lk_tag,
  input  logic                     lk_hit,
  input  logic [WAY_BITS-1:0]      lk_way,
  input  logic [1:0]               lk_mesi,
  output logic                     upd_valid,
  output logic [INDEX_BITS-1:0]    upd_index,
  output logic [WAY_BITS-1:0]      upd_way,
  output logic [1:0]               upd_mesi,
  output logic                     result_valid,
  output logic [1:0]               snoop_result,
  output logic                     l1_msg_valid,
  input  logic                     l1_msg_ready,
  output logic [2:0]               l1_msg,
  output logic [ADDRESS_WIDTH-1:0] l1_msg_addr,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [2:0]               bus_op,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  output logic                     proto_err
);

  localparam int unsigned LINE_W = ADDRESS_WIDTH - OFFSET_BITS;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_M = 2'b10;
  localparam logic [1:0] MESI_S = 2'b11;

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b11;

  localparam logic [2:0] MSG_NONE    = 3'd0;
  localparam logic [2:0] MSG_GETLINE = 3'd1;
  localparam logic [2:0] MSG_INVL    = 3'd3;
  localparam logic [2:0] MSG_EVICT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVAL,
    S_L1MSG,
    S_BUSWB
  } state_t;

  state_t state_q, state_d;

  logic [2:0]          op_q, op_d;
  logic [LINE_W-1:0]   addr_q, addr_d;
  logic                wb_q, wb_d;
  logic                snoop_ready_q, snoop_ready_d;
  logic                lk_req_q, lk_req_d;
  logic                upd_valid_q, upd_valid_d;
  logic [WAY_BITS-1:0] upd_way_q, upd_way_d;
  logic [1:0]          upd_mesi_q, upd_mesi_d;
  logic                result_valid_q, result_valid_d;
  logic [1:0]          snoop_result_q, snoop_result_d;
  logic                l1_msg_valid_q, l1_msg_valid_d;
  logic [2:0]          l1_msg_q, l1_msg_d;
  logic                bus_valid_q, bus_valid_d;
  logic [2:0]          bus_op_q, bus_op_d;
  logic                proto_err_q, proto_err_d;

  // Offset bits never influence a line-granular snoop.
  logic unused_offset;
  assign unused_offset = ^snoop_addr[OFFSET_BITS-1:0];

  // Action table evaluated on the lookup response; a miss reads as Invalid.
  logic [1:0] eff_mesi;
  logic [1:0] ev_result;
  logic       ev_upd;
  logic [1:0] ev_mesi;
  logic [2:0] ev_msg;
  logic       ev_wb;
  logic       ev_err;

  always_comb begin
    eff_mesi  = lk_hit ? lk_mesi : MESI_I;
    ev_result = RES_NOHIT;
    ev_upd    = 1'b0;
    ev_mesi   = MESI_I;
    ev_msg    = MSG_NONE;
    ev_wb     = 1'b0;
    ev_err    = 1'b0;
    case (op_q)
      OP_READ: begin
        case (eff_mesi)
          MESI_E: begin
            ev_result = RES_HIT;
            ev_upd    = 1'b1;
            ev_mesi   = MESI_S;
          end
          MESI_S: ev_result = RES_HIT;
          MESI_M: begin
            ev_result = RES_HITM;
            ev_upd    = 1'b1;
            ev_mesi   = MESI_S;
            ev_msg    = MSG_GETLINE;
            ev_wb     = 1'b1;
          end
          default: ;
        endcase
      end
      OP_WRITE: ev_err = (eff_mesi != MESI_I);
      OP_INV: begin
        case (eff_mesi)
          MESI_S: begin
            ev_result = RES_HIT;
            ev_upd    = 1'b1;
            ev_msg    = MSG_INVL;
          end
          MESI_E, MESI_M: ev_err = 1'b1;
          default: ;
        endcase
      end
      OP_RWIM: begin
        case (eff_mesi)
          MESI_E, MESI_S: begin
            ev_result = RES_HIT;
            ev_upd    = 1'b1;
            ev_msg    = MSG_INVL;
          end
          MESI_M: begin
            ev_result = RES_HITM;
            ev_upd    = 1'b1;
            ev_msg    = MSG_EVICT;
            ev_wb     = 1'b1;
          end
          default: ;
        endcase
      end
      default: ev_err = 1'b1;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wb_d           = wb_q;
    upd_way_d      = upd_way_q;
    upd_mesi_d     = upd_mesi_q;
    snoop_result_d = snoop_result_q;
    l1_msg_valid_d = l1_msg_valid_q;
    l1_msg_d       = l1_msg_q;
    bus_valid_d    = bus_valid_q;
    bus_op_d       = bus_op_q;
    lk_req_d       = 1'b0;
    upd_valid_d    = 1'b0;
    result_valid_d = 1'b0;
    proto_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snoop_valid) begin
          state_d  = S_LOOKUP;
          lk_req_d = 1'b1;
          op_d     = snoop_op;
          addr_d   = snoop_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
        end
      end
      S_LOOKUP: state_d = S_EVAL;
      S_EVAL: begin
        result_valid_d = 1'b1;
        snoop_result_d = ev_result;
        proto_err_d    = ev_err;
        upd_valid_d    = ev_upd;
        upd_way_d      = lk_way;
        upd_mesi_d     = ev_mesi;
        wb_d           = ev_wb;
        if (ev_msg != MSG_NONE) begin
          state_d        = S_L1MSG;
          l1_msg_valid_d = 1'b1;
          l1_msg_d       = ev_msg;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L1MSG: begin
        if (l1_msg_ready) begin
          l1_msg_valid_d = 1'b0;
          if (wb_q) begin
            state_d     = S_BUSWB;
            bus_valid_d = 1'b1;
            bus_op_d    = OP_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BUSWB: begin
        if (bus_ready) begin
          state_d     = S_IDLE;
          bus_valid_d = 1'b0;
          bus_op_d    = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    snoop_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= 3'd0;
      addr_q         <= '0;
      wb_q           <= 1'b0;
      snoop_ready_q  <= 1'b1;
      lk_req_q       <= 1'b0;
      upd_valid_q    <= 1'b0;
      upd_way_q      <= '0;
      upd_mesi_q     <= MESI_I;
      result_valid_q <= 1'b0;
      snoop_result_q <= RES_NOHIT;
      l1_msg_valid_q <= 1'b0;
      l1_msg_q       <= MSG_NONE;
      bus_valid_q    <= 1'b0;
      bus_op_q       <= 3'd0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wb_q           <= wb_d;
      snoop_ready_q  <= snoop_ready_d;
      lk_req_q       <= lk_req_d;
      upd_valid_q    <= upd_valid_d;
      upd_way_q      <= upd_way_d;
      upd_mesi_q     <= upd_mesi_d;
      result_valid_q <= result_valid_d;
      snoop_result_q <= snoop_result_d;
      l1_msg_valid_q <= l1_msg_valid_d;
      l1_msg_q       <= l1_msg_d;
      bus_valid_q    <= bus_valid_d;
      bus_op_q       <= bus_op_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign snoop_ready  = snoop_ready_q;
  assign lk_req       = lk_req_q;
  assign lk_index     = addr_q[INDEX_BITS-1:0];
  assign lk_tag       = addr_q[INDEX_BITS +: TAG_BITS];
  assign upd_valid    = upd_valid_q;
  assign upd_index    = addr_q[INDEX_BITS-1:0];
  assign upd_way      = upd_way_q;
  assign upd_mesi     = upd_mesi_q;
  assign result_valid = result_valid_q;
  assign snoop_result = snoop_result_q;
  assign l1_msg_valid = l1_msg_valid_q;
  assign l1_msg       = l1_msg_q;
  assign l1_msg_addr  = {addr_q, {OFFSET_BITS{1'b0}}};
  assign bus_valid    = bus_valid_q;
  assign bus_op       = bus_op_q;
  assign bus_addr     = {addr_q, {OFFSET_BITS{1'b0}}};
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: cycle model plus directed snoops.
module tb_snoop_responder;

  logic        clk;
  logic        rst_n;
  logic        snoop_valid;
  logic        snoop_ready;
  logic [2:0]  snoop_op;
  logic [31:0] snoop_addr;
  logic        lk_req;
  logic [13:0] lk_index;
  logic [11:0] lk_tag;
  logic        lk_hit;
  logic [3:0]  lk_way;
  logic [1:0]  lk_mesi;
  logic        upd_valid;
  logic [13:0] upd_index;
  logic [3:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        result_valid;
  logic [1:0]  snoop_result;
  logic        l1_msg_valid;
  logic        l1_msg_ready;
  logic [2:0]  l1_msg;
  logic [31:0] l1_msg_addr;
  logic        bus_valid;
  logic        bus_ready;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic        proto_err;

  snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_hit(lk_hit), .lk_way(lk_way), .lk_mesi(lk_mesi),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .result_valid(result_valid), .snoop_result(snoop_result),
    .l1_msg_valid(l1_msg_valid), .l1_msg_ready(l1_msg_ready),
    .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_op(bus_op), .bus_addr(bus_addr),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec action table: result, update, new state, message, writeback, error.
  function automatic void decide(input logic [2:0] op, input logic hit, input logic [1:0] mesi,
                                 output logic [1:0] res, output logic upd, output logic [1:0] nm,
                                 output logic [2:0] msg, output logic wb, output logic err);
    logic [1:0] s;
    s = hit ? mesi : 2'b00;
    res = 2'b11; upd = 1'b0; nm = 2'b00; msg = 3'd0; wb = 1'b0; err = 1'b0;
    if (op == 3'd1) begin
      if (s == 2'b01 || s == 2'b11) res = 2'b00;
      if (s == 2'b01) begin upd = 1'b1; nm = 2'b11; end
      if (s == 2'b10) begin res = 2'b01; upd = 1'b1; nm = 2'b11; msg = 3'd1; wb = 1'b1; end
    end else if (op == 3'd2) begin
      err = (s != 2'b00);
    end else if (op == 3'd3) begin
      if (s == 2'b11) begin res = 2'b00; upd = 1'b1; nm = 2'b00; msg = 3'd3; end
      else if (s != 2'b00) err = 1'b1;
    end else if (op == 3'd4) begin
      if (s != 2'b00) begin upd = 1'b1; nm = 2'b00; end
      if (s == 2'b01 || s == 2'b11) begin res = 2'b00; msg = 3'd3; end
      if (s == 2'b10) begin res = 2'b01; msg = 3'd4; wb = 1'b1; end
    end else begin
      err = 1'b1;
    end
  endfunction

  // Expected outputs for the cycle that begins at each rising edge.
  logic        e_ready = 1'b1, e_lk_req = 1'b0, e_upd_valid = 1'b0, e_res_valid = 1'b0;
  logic        e_err = 1'b0, e_msg_valid = 1'b0, e_bus_valid = 1'b0;
  logic [1:0]  e_result = 2'b11, e_upd_mesi = 2'b00;
  logic [3:0]  e_upd_way = 4'd0;
  logic [2:0]  e_msg = 3'd0;
  logic [31:0] m_addr = 32'd0;
  logic [2:0]  m_op = 3'd0;
  logic        m_wb = 1'b0, m_busy = 1'b0;
  int          cyc = 0, m_lcyc = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] r, nm;
    logic       u, wb, er;
    logic [2:0] msg;
    if (!rst_n) begin
      e_ready = 1'b1; e_lk_req = 1'b0; e_upd_valid = 1'b0; e_res_valid = 1'b0;
      e_err = 1'b0; e_msg_valid = 1'b0; e_bus_valid = 1'b0; e_result = 2'b11;
      m_busy = 1'b0; m_wb = 1'b0;
    end else begin
      cyc++;
      e_lk_req = 1'b0; e_upd_valid = 1'b0; e_res_valid = 1'b0; e_err = 1'b0;
      if (e_bus_valid && bus_ready) begin
        e_bus_valid = 1'b0;
        m_busy = 1'b0;
      end
      if (e_msg_valid && l1_msg_ready) begin
        e_msg_valid = 1'b0;
        if (m_wb) e_bus_valid = 1'b1;
        else m_busy = 1'b0;
      end
      if (m_busy && cyc == m_lcyc + 2) begin
        decide(m_op, lk_hit, lk_mesi, r, u, nm, msg, wb, er);
        e_res_valid = 1'b1;
        e_result    = r;
        e_upd_valid = u;
        e_upd_way   = lk_way;
        e_upd_mesi  = nm;
        e_err       = er;
        m_wb        = wb;
        if (msg != 3'd0) begin
          e_msg_valid = 1'b1;
          e_msg = msg;
        end else begin
          m_busy = 1'b0;
        end
      end
      if (e_ready && snoop_valid) begin
        m_busy = 1'b1; m_lcyc = cyc; m_op = snoop_op; m_addr = snoop_addr;
        e_lk_req = 1'b1;
      end
      e_ready = !m_busy;
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    chk("snoop_ready", 32'(snoop_ready), 32'(e_ready));
    chk("lk_req", 32'(lk_req), 32'(e_lk_req));
    chk("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
    chk("result_valid", 32'(result_valid), 32'(e_res_valid));
    chk("proto_err", 32'(proto_err), 32'(e_err));
    chk("l1_msg_valid", 32'(l1_msg_valid), 32'(e_msg_valid));
    chk("bus_valid", 32'(bus_valid), 32'(e_bus_valid));
    if (e_lk_req) begin
      chk("lk_index", 32'(lk_index), 32'(m_addr[19:6]));
      chk("lk_tag", 32'(lk_tag), 32'(m_addr[31:20]));
    end
    if (e_upd_valid) begin
      chk("upd_index", 32'(upd_index), 32'(m_addr[19:6]));
      chk("upd_way", 32'(upd_way), 32'(e_upd_way));
      chk("upd_mesi", 32'(upd_mesi), 32'(e_upd_mesi));
    end
    if (e_res_valid || !rst_n) chk("snoop_result", 32'(snoop_result), 32'(e_result));
    if (e_msg_valid) begin
      chk("l1_msg", 32'(l1_msg), 32'(e_msg));
      chk("l1_msg_addr", l1_msg_addr, {m_addr[31:6], 6'b0});
    end
    if (e_bus_valid) begin
      chk("bus_op", 32'(bus_op), 32'd2);
      chk("bus_addr", bus_addr, {m_addr[31:6], 6'b0});
    end
  end

  int n_res = 0, n_lk = 0, n_msg_cyc = 0, n_bus_cyc = 0;
  always @(negedge clk) begin
    if (result_valid) n_res++;
    if (lk_req) n_lk++;
    if (l1_msg_valid) n_msg_cyc++;
    if (bus_valid) n_bus_cyc++;
  end

  logic [13:0] o_lk_index;
  logic [11:0] o_lk_tag;
  logic [1:0]  o_result, o_upd_mesi;
  logic [3:0]  o_upd_way;
  logic        o_upd_valid, o_err, o_ready, o_msg_valid;
  logic [2:0]  o_msg;
  logic [31:0] o_msg_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (e_ready && snoop_ready) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got snoop_ready=%0b expected 1", snoop_ready);
  endtask

  task automatic clr_counts();
    n_res = 0; n_lk = 0; n_msg_cyc = 0; n_bus_cyc = 0;
  endtask

  // One snoop; msg_wait/bus_wait are ready-low cycles, bus_wait<0 leaves the writeback pending.
  task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input logic hit,
                          input logic [3:0] way, input logic [1:0] mesi,
                          input int msg_wait, input int bus_wait);
    snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
    tick();
    snoop_valid = 1'b0; snoop_op = 3'd0; snoop_addr = 32'd0;
    o_lk_index = lk_index; o_lk_tag = lk_tag;
    tick();
    lk_hit = hit; lk_way = way; lk_mesi = mesi;
    tick();
    lk_hit = 1'b0; lk_way = 4'hF; lk_mesi = 2'b10;
    o_result = snoop_result; o_upd_valid = upd_valid; o_upd_way = upd_way;
    o_upd_mesi = upd_mesi; o_err = proto_err; o_ready = snoop_ready;
    o_msg_valid = l1_msg_valid; o_msg = l1_msg; o_msg_addr = l1_msg_addr;
    repeat (msg_wait) tick();
    l1_msg_ready = 1'b1;
    tick();
    l1_msg_ready = 1'b0;
    if (bus_wait >= 0) begin
      repeat (bus_wait) tick();
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      wait_idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] ops [3];
    int k;
    rst_n = 1'b0; snoop_valid = 1'b0; snoop_op = 3'd0; snoop_addr = 32'd0;
    lk_hit = 1'b0; lk_way = 4'd0; lk_mesi = 2'b00; l1_msg_ready = 1'b0; bus_ready = 1'b0;
    repeat (3) tick();
    chk("reset_ready", 32'(snoop_ready), 32'd1);
    chk("reset_result", 32'(snoop_result), 32'd3);
    chk("reset_bus_valid", 32'(bus_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // READ, E hit in way 5
    do_snoop(3'd1, 32'h1234_5678, 1'b1, 4'd5, 2'b01, 0, 0);
    chk("rd_e_index", 32'(o_lk_index), 32'h1159);
    chk("rd_e_tag", 32'(o_lk_tag), 32'h123);
    chk("rd_e_result", 32'(o_result), 32'd0);
    chk("rd_e_upd", 32'(o_upd_valid), 32'd1);
    chk("rd_e_upd_way", 32'(o_upd_way), 32'd5);
    chk("rd_e_upd_mesi", 32'(o_upd_mesi), 32'd3);
    chk("rd_e_ready", 32'(o_ready), 32'd1);

    // READ, M hit in way 2 with a slow L1 and slow bus
    clr_counts();
    do_snoop(3'd1, 32'h1234_5678, 1'b1, 4'd2, 2'b10, 3, 2);
    chk("rd_m_result", 32'(o_result), 32'd1);
    chk("rd_m_upd_mesi", 32'(o_upd_mesi), 32'd3);
    chk("rd_m_msg", 32'(o_msg), 32'd1);
    chk("rd_m_msg_addr", o_msg_addr, 32'h1234_5640);
    chk("rd_m_msg_cycles", 32'(n_msg_cyc), 32'd4);
    chk("rd_m_bus_cycles", 32'(n_bus_cyc), 32'd3);

    // RWIM, M hit: evict then writeback with ready already high
    clr_counts();
    do_snoop(3'd4, 32'hABCD_E0C0, 1'b1, 4'd7, 2'b10, 0, 0);
    chk("rwim_m_result", 32'(o_result), 32'd1);
    chk("rwim_m_upd_mesi", 32'(o_upd_mesi), 32'd0);
    chk("rwim_m_msg", 32'(o_msg), 32'd4);
    chk("rwim_m_bus_cycles", 32'(n_bus_cyc), 32'd1);

    // RWIM miss with stale M state
    do_snoop(3'd4, 32'h0000_0040, 1'b0, 4'd1, 2'b10, 0, 0);
    chk("rwim_miss_result", 32'(o_result), 32'd3);
    chk("rwim_miss_upd", 32'(o_upd_valid), 32'd0);
    chk("rwim_miss_msg", 32'(o_msg_valid), 32'd0);

    // INVALIDATE on S, then on E
    do_snoop(3'd3, 32'h0F0F_0F0F, 1'b1, 4'd3, 2'b11, 1, 0);
    chk("inv_s_result", 32'(o_result), 32'd0);
    chk("inv_s_upd_mesi", 32'(o_upd_mesi), 32'd0);
    chk("inv_s_msg", 32'(o_msg), 32'd3);
    do_snoop(3'd3, 32'h0F0F_0F0F, 1'b1, 4'd3, 2'b01, 0, 0);
    chk("inv_e_result", 32'(o_result), 32'd3);
    chk("inv_e_err", 32'(o_err), 32'd1);
    chk("inv_e_upd", 32'(o_upd_valid), 32'd0);

    // Illegal op and WRITE to a valid line
    do_snoop(3'd6, 32'h5555_5555, 1'b1, 4'd0, 2'b01, 0, 0);
    chk("op6_result", 32'(o_result), 32'd3);
    chk("op6_err", 32'(o_err), 32'd1);
    do_snoop(3'd2, 32'h5555_5555, 1'b1, 4'd0, 2'b11, 0, 0);
    chk("wr_s_err", 32'(o_err), 32'd1);
    chk("wr_s_result", 32'(o_result), 32'd3);

    // Back-to-back READ/WRITE/READ with snoop_valid held high
    clr_counts();
    ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd1;
    lk_hit = 1'b1; lk_way = 4'd1; lk_mesi = 2'b11;
    k = 0;
    snoop_valid = 1'b1; snoop_op = ops[0]; snoop_addr = 32'h0012_3440;
    for (int i = 0; i < 40 && k < 3; i++) begin
      tick();
      if (e_lk_req) begin
        k++;
        if (k == 3) snoop_valid = 1'b0;
        else snoop_op = ops[k];
      end
    end
    snoop_valid = 1'b0;
    repeat (3) tick();
    wait_idle();
    lk_hit = 1'b0;
    chk("b2b_results", 32'(n_res), 32'd3);
    chk("b2b_lookups", 32'(n_lk), 32'd3);

    // Reset while the writeback is pending
    do_snoop(3'd1, 32'h0000_1040, 1'b1, 4'd3, 2'b10, 0, -1);
    chk("pre_rst_bus_valid", 32'(bus_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_ready", 32'(snoop_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_snoop(3'd1, 32'h1234_5678, 1'b1, 4'd5, 2'b01, 0, 0);
    chk("post_rst_result", 32'(o_result), 32'd0);
    chk("post_rst_upd_mesi", 32'(o_upd_mesi), 32'd3);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Responder side of the shared-bus snoop protocol for the 16-way last-level cache.
- Accepts a snooped bus operation (READ, WRITE, INVALIDATE, RWIM) from another processor and looks up the line's MESI state in the tag array.
- Returns the snoop result (HIT/HITM/NOHIT) and updates MESI state.
- Issues the required L2-to-L1 message (GETLINE, INVALIDATELINE, EVICTLINE) and, on HITM, a bus WRITE writeback.

Parameters:
- ADDRESS_WIDTH, 32, snooped address width.
- OFFSET_BITS, 6, line offset bits (64 B line).
- INDEX_BITS, 14, set index bits (16384 sets).
- WAY_BITS, 4, way index width (16 ways).
- TAG_BITS, ADDRESS_WIDTH-INDEX_BITS-OFFSET_BITS (12), tag width.

Ports:
- clk  in  1  single clock; all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- snoop_valid  in  1  snoop request present.
- snoop_ready  out  1  block idle, can accept.
- snoop_op  in  3  1=READ 2=WRITE 3=INVALIDATE 4=RWIM.
- snoop_addr  in  ADDRESS_WIDTH  snooped address.
- lk_req  out  1  tag-array lookup strobe.
- lk_index  out  INDEX_BITS  lookup set.
- lk_tag  out  TAG_BITS  lookup tag.
- lk_hit  in  1  lookup hit; valid the cycle after lk_req.
- lk_way  in  WAY_BITS  hit way.
- lk_mesi  in  2  hit line state: I=00 E=01 M=10 S=11.
- upd_valid  out  1  one-cycle MESI update strobe.
- upd_index  out  INDEX_BITS  update set.
- upd_way  out  WAY_BITS  update way.
- upd_mesi  out  2  new state.
- result_valid  out  1  one-cycle snoop result strobe.
- snoop_result  out  2  HIT=00 HITM=01 NOHIT=11.
- l1_msg_valid / l1_msg_ready  out/in  1/1  L1 message handshake.
- l1_msg  out  3  GETLINE=1 INVALIDATELINE=3 EVICTLINE=4.
- l1_msg_addr  out  ADDRESS_WIDTH  line address, offset bits zeroed.
- bus_valid / bus_ready  out/in  1/1  writeback handshake.
- bus_op  out  3  always WRITE=2 while bus_valid.
- bus_addr  out  ADDRESS_WIDTH  line address, offset zeroed.
- proto_err  out  1  one-cycle pulse on illegal op or state.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except snoop_ready=1 and snoop_result=NOHIT. A reset mid-operation aborts without issuing pending update, message or writeback.
- FSM states: IDLE, LOOKUP, EVAL, L1MSG, BUSWB.
- snoop_ready=1 only in IDLE. Accept at cycle T when snoop_valid && snoop_ready; op and address are registered.
- T+1 (LOOKUP): lk_req=1 for exactly one cycle. lk_index=addr[19:6], lk_tag=addr[31:20].
- T+2 (EVAL): sample lk_hit/lk_way/lk_mesi. lk_hit=0 is treated as I regardless of lk_mesi.
- T+3: result_valid=1 for one cycle. upd_valid pulses in the same cycle only when the state changes.
- Next state after EVAL: L1MSG if a message is required; otherwise IDLE, with snoop_ready=1 at T+3.
- Action table (state -> result, new state, L1 message, writeback):
  - READ: I -> NOHIT. E -> HIT, S. S -> HIT, no update. M -> HITM, S, GETLINE, writeback.
  - WRITE: any state -> NOHIT, no action. If state is not I: proto_err.
  - INVALIDATE: I -> NOHIT. S -> HIT, I, INVALIDATELINE. E or M -> NOHIT, no update, proto_err.
  - RWIM: I -> NOHIT. E or S -> HIT, I, INVALIDATELINE. M -> HITM, I, EVICTLINE, writeback.
- Illegal snoop_op (0, 5-7): NOHIT, proto_err at T+3, no lookup side effects beyond lk_req.
- L1MSG: l1_msg_valid held with l1_msg/l1_msg_addr stable until l1_msg_ready. On the handshake cycle, go to BUSWB if a writeback is required, else IDLE.
- BUSWB: bus_valid held with bus_op=WRITE and bus_addr stable until bus_ready, then IDLE.
- Ordering: the writeback never precedes the L1 message handshake. If ready is already high, one handshake completes per cycle.
- No new snoop is accepted until return to IDLE; snoop_valid asserted while busy is ignored.

Test Plan:
- Reset mid-BUSWB (rst_n low 1 cycle) -> bus_valid=0, upd_valid=0, snoop_ready=1 immediately; next snoop is processed normally.
- READ 0x12345678, lk_hit=1, mesi=E, way 5 -> lk_index=0x1159, lk_tag=0x123 at T+1; at T+3 result HIT, upd way5 mesi=S; snoop_ready=1 at T+3.
- READ, mesi=M, way 2, l1_msg_ready held low 3 cycles -> result HITM, upd mesi=S; GETLINE addr 0x12345640 held 3 cycles then handshake; then bus WRITE 0x12345640 until bus_ready.
- RWIM, mesi=M -> HITM, upd I, EVICTLINE, then bus WRITE. RWIM with lk_hit=0 and mesi=M -> NOHIT, no update, no message.
- INVALIDATE, mesi=S -> HIT, upd I, INVALIDATELINE. INVALIDATE, mesi=E -> NOHIT, proto_err=1 for one cycle, no update.
- snoop_op=6 -> NOHIT, proto_err. Back-to-back READ/WRITE/READ with snoop_valid held high -> each accepted only in IDLE, one result_valid per snoop.
